matmul_engine_nxn: RTL and testbench
====================================

# matmul_engine_nxn

Parametrised successor to the team's fixed 2x2 matrix-multiply controller. It computes C = A·B, or C += A·B in accumulate mode, for signed N×N matrices. The block loads A and B element-by-element, feeds them with diagonal skew through an internal N×N output-stationary MAC grid, and streams C row-major over a valid/ready port with configurable saturation. It sits between the host load/readout bus and the rest of the datapath as a self-contained matmul unit.

## Interface
- N, 2: matrix dimension; valid range 2..8.
- DATA_W, 8: signed width of A and B elements.
- OUT_W, 8: signed width of out_data.
- SAT, 1: 1 = clamp result to OUT_W signed range; 0 = keep the low OUT_W bits.
- ACC_W (localparam): 2*DATA_W + clog2(N) + 4; internal accumulator width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- load_en  in  1  write in_data to the selected matrix element.
- load_sel_ab  in  1  0 = A, 1 = B.
- load_row  in  clog2(N)  element row.
- load_col  in  clog2(N)  element column.
- in_data  in  DATA_W  signed element value.
- load_ready  out  1  high in IDLE; loads are accepted only when this is high.
- acc_mode  in  1  sampled at IDLE→FEED; 1 = keep previous C and accumulate.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse in the first OUTPUT cycle.
- out_valid  out  1  C element available.
- out_ready  in  1  consumer accepts the element.
- out_data  out  OUT_W  current C element, row-major.
- out_last  out  1  high with the C[N-1][N-1] element.

## Operation
- State machine: IDLE → FEED → OUTPUT → IDLE.
- IDLE:
  - load_en writes A or B[load_row][load_col] and sets that element's loaded bit (N*N bits per matrix).
  - Rewriting an element overwrites it.
  - Row/col ≥ N are ignored.
  - When all A and B bits are set, the next edge enters FEED, feed counter t = 0, and acc_mode is latched.
  - If latched acc_mode = 0, all accumulators clear on that same edge.
- FEED, t = 0..3N-3 (3N-2 cycles):
  - Row input i receives A[i][t-i] when 0 ≤ t-i < N, else 0.
  - Column input j receives B[t-j][j] under the same rule.
  - The A operand moves one PE right per cycle; the B operand moves one PE down per cycle.
  - Each PE(i,j) adds a·b into its accumulator every cycle. Zero-padded operands contribute 0.
  - After t = 3N-3 the next state is OUTPUT.
- Arithmetic:
  - Products are signed DATA_W×DATA_W.
  - Accumulators are signed ACC_W and wrap on overflow.
  - SAT=1: a value above 2^(OUT_W-1)-1 outputs the maximum; a value below -2^(OUT_W-1) outputs the minimum.
  - SAT=0: out_data = acc[OUT_W-1:0].
- OUTPUT:
  - out_valid = 1.
  - out_data is the combinational mux of element index k (row-major), starting at k = 0.
  - k advances only on out_valid & out_ready.
  - out_data and out_last stay stable while out_ready = 0.
  - The handshake on k = N*N-1 returns the block to IDLE and clears all loaded bits. Accumulators retain C.
- Loads with load_ready = 0 are dropped and have no effect.
- The grid operand registers are zero in IDLE and OUTPUT.

## Timing
- Reset (rst = 0 at an edge): state IDLE, loaded bits 0, accumulators 0, counters 0, operand pipeline 0. Outputs after reset: busy = 0, done = 0, out_valid = 0, out_last = 0, out_data = 0, load_ready = 1.
- Reset mid-FEED or mid-OUTPUT aborts the operation. No partial output follows.
- Latency: the last load is accepted in cycle c. The block is in FEED from c+2 to c+3N-1. out_valid and done first assert in cycle c+3N (N=2: c+6).
- Readout: N*N cycles with out_ready held high; each cycle out_ready = 0 adds one cycle.
- IDLE re-entry follows the edge of the final handshake, so load_ready = 1 in the next cycle.
- A load and the final readout handshake in the same cycle: the load is dropped.
- out_data = 0 whenever out_valid = 0.

## Test plan
- Basic, N=2, SAT=1: load A=[[1,2],[3,4]], B=[[5,6],[7,8]], out_ready=1 → stream 19,22,43,50; out_last on 50; done pulse 6 cycles after the last load.
- Accumulate: repeat the same load with acc_mode=1 → 38,44,86,100. A third run with acc_mode=0 → 19,22,43,50.
- Saturation, N=2: all A=B=127 with SAT=1 → four outputs of 127. With SAT=0 → four outputs of 2 (32258 mod 256). All A=-128, B=127, SAT=1 → -128.
- Backpressure: toggle out_ready 1,0,0,1,… during readout → each element held stable while out_ready=0; exactly 4 handshakes; out_last only on the 4th.
- N=3: A = identity, B = 1..9 row-major → stream 1..9. Loads issued during FEED are ignored and the result is unchanged.
- Reset mid-FEED: rst=0 at t=2 → busy=0 and out_valid never asserts. After a fresh load of the basic case → 19,22,43,50.

Source files
------------

// File: rtl/matmul_engine_nxn_if.sv
// Host-side bus of the NxN matmul engine: element load port, run
// control/status and the row-major C readout stream.
interface matmul_engine_nxn_if #(
  parameter int N      = 2,
  parameter int DATA_W = 8,
  parameter int OUT_W  = 8
);
  localparam int IW = $clog2(N);

  logic                     load_en;
  logic                     load_sel_ab;
  logic [IW-1:0]            load_row;
  logic [IW-1:0]            load_col;
  logic signed [DATA_W-1:0] in_data;
  logic                     load_ready;
  logic                     acc_mode;
  logic                     busy;
  logic                     done;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_last;

  modport slave (
    input  load_en, load_sel_ab, load_row, load_col, in_data, acc_mode, out_ready,
    output load_ready, busy, done, out_valid, out_data, out_last
  );

  modport master (
    output load_en, load_sel_ab, load_row, load_col, in_data, acc_mode, out_ready,
    input  load_ready, busy, done, out_valid, out_data, out_last
  );
endinterface

// File: rtl/matmul_engine_nxn.sv
// NxN signed matrix multiply (C = A*B or C += A*B) on an output-stationary
// MAC grid. A enters from the left, B from the top, both diagonally skewed;
// C is streamed row-major with optional saturation.

// One grid cell: forwards its operands right/down and accumulates a*b.
module matmul_engine_nxn_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 21
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     mac_i,
  input  logic                     pass_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] a_o,
  output logic signed [DATA_W-1:0] b_o,
  output logic signed [ACC_W-1:0]  acc_o
);
  logic signed [DATA_W-1:0]   a_q, b_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [2*DATA_W-1:0] prod;

  assign prod  = a_i * b_i;
  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

  // Operand forwarding (zeroed outside feeding) and wrapping accumulation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q <= pass_i ? a_i : '0;
      b_q <= pass_i ? b_i : '0;
      if (clr_i)
        acc_q <= '0;
      else if (mac_i)
        acc_q <= acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    end
  end
endmodule

module matmul_engine_nxn #(
  parameter int N      = 2,
  parameter int DATA_W = 8,
  parameter int OUT_W  = 8,
  parameter int SAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  matmul_engine_nxn_if.slave bus
);
  localparam int ACC_W = 2*DATA_W + $clog2(N) + 4;
  localparam int IW    = $clog2(N);
  localparam int TW    = $clog2(3*N-2);
  localparam int NN    = N*N;
  localparam int KW    = $clog2(NN);
  localparam logic [TW-1:0] LAST_T = TW'(3*N-3);
  localparam logic [KW-1:0] LAST_K = KW'(NN-1);
  localparam logic signed [ACC_W-1:0] OMAX = ACC_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] OMIN = ~OMAX;

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_OUT} state_t;

  state_t state_q, state_d;
  logic [TW-1:0] t_q;
  logic [KW-1:0] k_q;
  logic          done_q;

  logic [N-1:0][N-1:0][DATA_W-1:0] a_mat_q, b_mat_q;
  logic [N-1:0][N-1:0]             lda_q, ldb_q;

  logic [N-1:0][DATA_W-1:0]        a_feed, b_feed;
  logic [N-1:0][N-1:0][DATA_W-1:0] a_in, b_in, a_out, b_out;
  logic [NN-1:0][ACC_W-1:0]        acc_w;
  logic signed [ACC_W-1:0]         acc_sel;
  logic signed [OUT_W-1:0]         res;

  logic start, fin, mac_en, pass_en, acc_clr, last_t;

  assign last_t  = (t_q == LAST_T);
  assign start   = (state_q == S_IDLE) && (&lda_q) && (&ldb_q);
  assign fin     = (state_q == S_OUT) && bus.out_ready && (k_q == LAST_K);
  assign mac_en  = (state_q == S_FEED);
  assign pass_en = (state_q == S_FEED) && !last_t;
  assign acc_clr = start && !bus.acc_mode;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state: loads complete -> feed 3N-2 skewed cycles -> drain C.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)  state_d = S_FEED;
      S_FEED:  if (last_t) state_d = S_OUT;
      S_OUT:   if (fin)    state_d = S_IDLE;
      default:             state_d = S_IDLE;
    endcase
  end

  // Feed cycle counter, readout index and the one-shot done flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      t_q    <= '0;
      k_q    <= '0;
      done_q <= 1'b0;
    end else begin
      t_q    <= (state_q == S_FEED && !last_t) ? t_q + 1'b1 : '0;
      done_q <= (state_q == S_FEED) && last_t;
      if (state_q != S_OUT)
        k_q <= '0;
      else if (bus.out_ready)
        k_q <= fin ? '0 : k_q + 1'b1;
    end
  end

  // Element store and per-matrix loaded bits; only written while idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_mat_q <= '0;
      b_mat_q <= '0;
      lda_q   <= '0;
      ldb_q   <= '0;
    end else if (fin) begin
      lda_q <= '0;
      ldb_q <= '0;
    end else if (bus.load_en && state_q == S_IDLE) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          if (bus.load_row == IW'(r) && bus.load_col == IW'(c)) begin
            if (bus.load_sel_ab) begin
              b_mat_q[r][c] <= bus.in_data;
              ldb_q[r][c]   <= 1'b1;
            end else begin
              a_mat_q[r][c] <= bus.in_data;
              lda_q[r][c]   <= 1'b1;
            end
          end
    end
  end

  // Skewed edge inputs: row i gets A[i][t-i], column j gets B[t-j][j].
  always_comb begin
    a_feed = '0;
    b_feed = '0;
    if (state_q == S_FEED)
      for (int i = 0; i < N; i++)
        for (int k = 0; k < N; k++)
          if (int'(t_q) == i + k) begin
            a_feed[i] = a_mat_q[i][k];
            b_feed[i] = b_mat_q[k][i];
          end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      if (j == 0) begin : g_al
        assign a_in[i][j] = a_feed[i];
      end else begin : g_ai
        assign a_in[i][j] = a_out[i][j-1];
      end
      if (i == 0) begin : g_bt
        assign b_in[i][j] = b_feed[j];
      end else begin : g_bi
        assign b_in[i][j] = b_out[i-1][j];
      end
      matmul_engine_nxn_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clr_i (acc_clr),
        .mac_i (mac_en),
        .pass_i(pass_en),
        .a_i   (a_in[i][j]),
        .b_i   (b_in[i][j]),
        .a_o   (a_out[i][j]),
        .b_o   (b_out[i][j]),
        .acc_o (acc_w[i*N+j])
      );
    end
  end

  assign acc_sel = acc_w[k_q];

  // Clamp or truncate the selected accumulator to the output width.
  always_comb begin
    res = acc_sel[OUT_W-1:0];
    if (SAT != 0) begin
      if (acc_sel > OMAX)      res = OMAX[OUT_W-1:0];
      else if (acc_sel < OMIN) res = OMIN[OUT_W-1:0];
    end
  end

  assign bus.load_ready = (state_q == S_IDLE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = done_q;
  assign bus.out_valid  = (state_q == S_OUT);
  assign bus.out_data   = (state_q == S_OUT) ? res : '0;
  assign bus.out_last   = (state_q == S_OUT) && (k_q == LAST_K);
endmodule

// File: tb/tb_matmul_engine_nxn.sv
// Bench for matmul_engine_nxn: two N=2 engines (SAT=1 / SAT=0) sharing one
// stimulus, plus an N=3 engine; results compared against a matrix model.
module tb_matmul_engine_nxn;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              ld_en = 0, ld_ab = 0, acc_m = 0, o_rdy = 0, grp = 0;
  logic [1:0]        ld_row = '0, ld_col = '0;
  logic signed [7:0] ld_data = '0;
  int                n_chk = 0, n_err = 0;
  longint            cm[2][3][3];

  matmul_engine_nxn_if #(.N(2)) if2s ();
  matmul_engine_nxn_if #(.N(2)) if2w ();
  matmul_engine_nxn_if #(.N(3)) if3 ();

  assign if2s.load_en = ld_en && !grp;  assign if2w.load_en = ld_en && !grp;  assign if3.load_en = ld_en && grp;
  assign if2s.load_sel_ab = ld_ab;      assign if2w.load_sel_ab = ld_ab;      assign if3.load_sel_ab = ld_ab;
  assign if2s.load_row = ld_row[0];     assign if2w.load_row = ld_row[0];     assign if3.load_row = ld_row;
  assign if2s.load_col = ld_col[0];     assign if2w.load_col = ld_col[0];     assign if3.load_col = ld_col;
  assign if2s.in_data = ld_data;        assign if2w.in_data = ld_data;        assign if3.in_data = ld_data;
  assign if2s.acc_mode = acc_m;         assign if2w.acc_mode = acc_m;         assign if3.acc_mode = acc_m;
  assign if2s.out_ready = o_rdy;        assign if2w.out_ready = o_rdy;        assign if3.out_ready = o_rdy;

  matmul_engine_nxn #(.N(2), .SAT(1)) u2s (.clk(clk), .rst(rst), .bus(if2s.slave));
  matmul_engine_nxn #(.N(2), .SAT(0)) u2w (.clk(clk), .rst(rst), .bus(if2w.slave));
  matmul_engine_nxn #(.N(3), .SAT(1)) u3  (.clk(clk), .rst(rst), .bus(if3.slave));

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  function automatic longint wrapw(input longint v, input int w);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction

  function automatic longint clamp8(input longint v);
    return (v > 127) ? 127 : (v < -128) ? -128 : v;
  endfunction

  function automatic logic o_valid(); return grp ? if3.out_valid  : if2s.out_valid;  endfunction
  function automatic logic o_last();  return grp ? if3.out_last   : if2s.out_last;   endfunction
  function automatic logic o_done();  return grp ? if3.done       : if2s.done;       endfunction
  function automatic logic o_busy();  return grp ? if3.busy       : if2s.busy;       endfunction
  function automatic logic o_lrdy();  return grp ? if3.load_ready : if2s.load_ready; endfunction
  function automatic longint o_data(); return grp ? longint'(if3.out_data) : longint'(if2s.out_data); endfunction

  // Writes every element once (after a throwaway write to A[0][0]); returns
  // at the negedge of the cycle following the final accepted load.
  task automatic do_loads(input int a[3][3], input int b[3][3]);
    int n = grp ? 3 : 2;
    @(negedge clk);
    ld_en = 1; ld_ab = 0; ld_row = 0; ld_col = 0; ld_data = 8'sh55;
    if (grp) begin
      @(negedge clk);
      ld_row = 2'd3; ld_col = 2'd1; ld_data = -8'sd1;
    end
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < n; i++)
        for (int j = 0; j < n; j++) begin
          @(negedge clk);
          chk("load_ready", o_lrdy(), 1);
          ld_ab = m[0]; ld_row = 2'(i); ld_col = 2'(j);
          ld_data = 8'(m ? b[i][j] : a[i][j]);
        end
    @(negedge clk);
    ld_en = 0;
  endtask

  task automatic run_mm(input int a[3][3], input int b[3][3], input bit accm,
                        input int rmode, input bit feed_ld);
    int n = grp ? 3 : 2;
    int k, cyc, hs, ei, ej;
    bit got;
    longint s;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int q = 0; q < n; q++) s += longint'(a[i][q] * b[q][j]);
        cm[grp][i][j] = wrapw(accm ? cm[grp][i][j] + s : s, grp ? 22 : 21);
      end
    acc_m = accm;
    do_loads(a, b);
    k = 1; got = 0;
    while (k <= 3*n + 4) begin
      if (k == 2) begin
        chk("busy_feed", o_busy(), 1);
        chk("lrdy_feed", o_lrdy(), 0);
      end
      if (feed_ld && k == 4) begin
        ld_en = 1; ld_ab = 0; ld_row = 0; ld_col = 0; ld_data = 8'sh7f;
      end else ld_en = 0;
      if (o_done()) begin got = 1; break; end
      @(negedge clk); k++;
    end
    ld_en = 0;
    chk("latency", got ? k : -1, 3*n);
    if (!got) return;
    hs = 0; cyc = 0;
    while (hs < n*n && cyc < 100) begin
      case (rmode)
        0:       o_rdy = 1;
        1:       o_rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: o_rdy = $urandom_range(1);
      endcase
      if (cyc < 2) chk("done", o_done(), cyc == 0);
      ei = hs / n; ej = hs % n;
      chk("valid", o_valid(), 1);
      chk("last", o_last(), hs == n*n - 1);
      chk("data", o_data(), clamp8(cm[grp][ei][ej]));
      if (!grp) chk("data_wrap", longint'(if2w.out_data), wrapw(cm[grp][ei][ej], 8));
      if (o_rdy) hs++;
      @(negedge clk); cyc++;
    end
    o_rdy = 0;
    chk("handshakes", hs, n*n);
    chk("idle_lrdy", o_lrdy(), 1);
    chk("idle_busy", o_busy(), 0);
    chk("idle_valid", o_valid(), 0);
    chk("idle_data", o_data(), 0);
  endtask

  // Aborts a run at feed step t=2 and checks nothing is ever output.
  task automatic rst_mid(input int a[3][3], input int b[3][3]);
    int cnt = 0;
    acc_m = 0;
    do_loads(a, b);
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    rst = 1;
    chk("rst_busy", o_busy(), 0);
    repeat (12) begin
      @(negedge clk);
      if (o_valid()) cnt++;
    end
    chk("rst_novalid", cnt, 0);
    foreach (cm[g, i, j]) cm[g][i][j] = 0;
  endtask

  initial begin
    int A[3][3], B[3][3], I3[3][3], S[3][3];
    foreach (cm[g, i, j]) cm[g][i][j] = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy2", if2s.busy, 0);
    chk("rst_done2", if2s.done, 0);
    chk("rst_valid2", if2s.out_valid, 0);
    chk("rst_last2", if2s.out_last, 0);
    chk("rst_data2", longint'(if2s.out_data), 0);
    chk("rst_lrdy2", if2s.load_ready, 1);
    chk("rst_valid3", if3.out_valid, 0);
    chk("rst_lrdy3", if3.load_ready, 1);
    rst = 1;

    grp = 0;
    A = '{'{1, 2, 0}, '{3, 4, 0}, '{0, 0, 0}};
    B = '{'{5, 6, 0}, '{7, 8, 0}, '{0, 0, 0}};
    run_mm(A, B, 0, 0, 0);
    run_mm(A, B, 1, 1, 0);
    run_mm(A, B, 0, 0, 0);

    S = '{'{127, 127, 0}, '{127, 127, 0}, '{0, 0, 0}};
    run_mm(S, S, 0, 0, 0);
    I3 = '{'{-128, -128, 0}, '{-128, -128, 0}, '{0, 0, 0}};
    run_mm(I3, S, 0, 1, 0);

    grp = 1;
    I3 = '{'{1, 0, 0}, '{0, 1, 0}, '{0, 0, 1}};
    S  = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
    run_mm(I3, S, 0, 0, 1);

    grp = 0;
    rst_mid(A, B);
    run_mm(A, B, 1, 0, 0);

    for (int r = 0; r < 6; r++) begin
      grp = r[0];
      foreach (S[i, j]) begin
        S[i][j] = int'($urandom_range(255)) - 128;
        I3[i][j] = int'($urandom_range(255)) - 128;
      end
      run_mm(S, I3, (r > 1) && $urandom_range(1) == 1, 2, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
